// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/forward control for the Decode->Execute->Memory pipeline registers.
// Optional perf counters (stall_cnt, flush_cnt) are built when PERF_COUNTERS_EN is defined.
module pipeline_hazard_controller #(
    parameter int REG_AW       = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int PERF_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] src1_decode,
    input  logic [REG_AW-1:0] src2_decode,
    input  logic              use_src1,
    input  logic              use_src2,
    input  logic [REG_AW-1:0] reg_dest_execute,
    input  logic              wbs_execute,
    input  logic              mm_execute,
    input  logic [REG_AW-1:0] reg_dest_memory,
    input  logic              wbs_memory,
    input  logic              mem_req,
    input  logic              mem_ack,
    input  logic              branch_taken,
    output logic              stall_fetch,
    output logic              stall_decode,
    output logic              stall_execute,
    output logic              flush_fetch,
    output logic              flush_decode,
    output logic [1:0]        fwdA_sel,
    output logic [1:0]        fwdB_sel,
`ifdef PERF_COUNTERS_EN
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt,
`endif
    output logic [1:0]        state_dbg
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FLUSH    = 2'b10,
        ILLEGAL  = 2'b11
    } state_e;

    if (FLUSH_CYCLES < 1 || PERF_W < 1) begin : g_bad_params
        $error("pipeline_hazard_controller: FLUSH_CYCLES and PERF_W must be >= 1");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;

    logic       mem_wait_start;
    logic       load_use;
    logic       branch_now;
    logic [1:0] fwd_a_live;
    logic [1:0] fwd_b_live;

    logic       stall_fetch_c;
    logic       stall_decode_c;
    logic       stall_execute_c;
    logic       flush_fetch_c;
    logic       flush_decode_c;
    logic [1:0] fwd_a_c;
    logic [1:0] fwd_b_c;

    // Execute-stage ALU results win over memory-stage results; loads in execute cannot forward.
    function automatic logic [1:0] fwd_select(
        input logic              use_src,
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] dest_ex,
        input logic              wb_ex,
        input logic              mm_ex,
        input logic [REG_AW-1:0] dest_mem,
        input logic              wb_mem
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (use_src) begin
            if (wb_ex && !mm_ex && (dest_ex == src)) begin
                sel = 2'b01;
            end else if (wb_mem && (dest_mem == src)) begin
                sel = 2'b10;
            end
        end
        return sel;
    endfunction

    always_comb begin
        mem_wait_start = mem_req & ~mem_ack;
        load_use = mm_execute & wbs_execute &
                   ((use_src1 & (src1_decode == reg_dest_execute)) |
                    (use_src2 & (src2_decode == reg_dest_execute)));
        // A pending memory wait defers the branch until the access completes.
        branch_now = branch_taken & ~mem_wait_start;
        fwd_a_live = fwd_select(use_src1, src1_decode, reg_dest_execute, wbs_execute,
                                mm_execute, reg_dest_memory, wbs_memory);
        fwd_b_live = fwd_select(use_src2, src2_decode, reg_dest_execute, wbs_execute,
                                mm_execute, reg_dest_memory, wbs_memory);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        fwd_a_d = (state_q == MEM_WAIT) ? fwd_a_q : fwd_a_live;
        fwd_b_d = (state_q == MEM_WAIT) ? fwd_b_q : fwd_b_live;
        case (state_q)
            RUN: begin
                if (mem_wait_start) begin
                    state_d = MEM_WAIT;
                end else if (branch_taken && (FLUSH_CYCLES > 1)) begin
                    // The RUN cycle already counts as the first flush cycle.
                    state_d = FLUSH;
                    fcnt_d  = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    if (branch_taken) begin
                        state_d = FLUSH;
                        fcnt_d  = CNT_W'(FLUSH_CYCLES);
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            FLUSH: begin
                if (fcnt_q <= CNT_W'(1)) begin
                    state_d = RUN;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                fcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        stall_fetch_c   = 1'b0;
        stall_decode_c  = 1'b0;
        stall_execute_c = 1'b0;
        flush_fetch_c   = 1'b0;
        flush_decode_c  = 1'b0;
        fwd_a_c         = fwd_a_live;
        fwd_b_c         = fwd_b_live;
        case (state_q)
            RUN: begin
                if (branch_now) begin
                    flush_fetch_c  = 1'b1;
                    flush_decode_c = 1'b1;
                end else if (load_use) begin
                    stall_fetch_c  = 1'b1;
                    flush_decode_c = 1'b1;
                end
            end
            MEM_WAIT: begin
                stall_fetch_c   = 1'b1;
                stall_decode_c  = 1'b1;
                stall_execute_c = 1'b1;
                fwd_a_c         = fwd_a_q;
                fwd_b_c         = fwd_b_q;
            end
            FLUSH: begin
                flush_fetch_c  = 1'b1;
                flush_decode_c = 1'b1;
            end
            default: begin
                fwd_a_c = fwd_a_live;
                fwd_b_c = fwd_b_live;
            end
        endcase
    end

    // Every output reads as zero for as long as reset is held.
    always_comb begin
        stall_fetch   = rst_n & stall_fetch_c;
        stall_decode  = rst_n & stall_decode_c;
        stall_execute = rst_n & stall_execute_c;
        flush_fetch   = rst_n & flush_fetch_c;
        flush_decode  = rst_n & flush_decode_c;
        fwdA_sel      = rst_n ? fwd_a_c : 2'b00;
        fwdB_sel      = rst_n ? fwd_b_c : 2'b00;
        state_dbg     = rst_n ? state_q : 2'b00;
    end

`ifdef PERF_COUNTERS_EN
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_fetch && (stall_cnt_q != {PERF_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_fetch && (flush_cnt_q != {PERF_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: vector table, directed multi-cycle sequences,
// then random stimulus against a cycle-level model of the hazard rules.
module tb_pipeline_hazard_controller;

    localparam int REG_AW = 4;
    localparam int FC     = 2;
    localparam int PW     = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [REG_AW-1:0] src1_decode, src2_decode, reg_dest_execute, reg_dest_memory;
    logic use_src1, use_src2, wbs_execute, mm_execute, wbs_memory;
    logic mem_req, mem_ack, branch_taken;
    logic stall_fetch, stall_decode, stall_execute, flush_fetch, flush_decode;
    logic [1:0] fwdA_sel, fwdB_sel, state_dbg;
`ifdef PERF_COUNTERS_EN
    logic [PW-1:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.REG_AW(REG_AW), .FLUSH_CYCLES(FC), .PERF_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .src1_decode(src1_decode), .src2_decode(src2_decode),
        .use_src1(use_src1), .use_src2(use_src2),
        .reg_dest_execute(reg_dest_execute), .wbs_execute(wbs_execute), .mm_execute(mm_execute),
        .reg_dest_memory(reg_dest_memory), .wbs_memory(wbs_memory),
        .mem_req(mem_req), .mem_ack(mem_ack), .branch_taken(branch_taken),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode), .stall_execute(stall_execute),
        .flush_fetch(flush_fetch), .flush_decode(flush_decode),
        .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel),
`ifdef PERF_COUNTERS_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .state_dbg(state_dbg)
    );

    typedef struct packed {
        logic [3:0] s1;
        logic [3:0] s2;
        logic       u1;
        logic       u2;
        logic [3:0] dex;
        logic       wex;
        logic       mmex;
        logic [3:0] dmem;
        logic       wmem;
        logic       req;
        logic       ack;
        logic       br;
    } in_t;

    typedef struct {
        in_t        in;
        logic [10:0] exp;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Output bundle: {stall_f, stall_d, stall_e, flush_f, flush_d, fwdA, fwdB, state}
    function automatic logic [10:0] outs();
        return {stall_fetch, stall_decode, stall_execute, flush_fetch, flush_decode,
                fwdA_sel, fwdB_sel, state_dbg};
    endfunction

    function automatic in_t mkin(input int s1, input int s2, input bit u1, input bit u2,
                                 input int dex, input bit wex, input bit mm,
                                 input int dmem, input bit wmem,
                                 input bit req, input bit ack, input bit br);
        in_t v;
        v.s1 = 4'(s1); v.s2 = 4'(s2); v.u1 = u1; v.u2 = u2;
        v.dex = 4'(dex); v.wex = wex; v.mmex = mm;
        v.dmem = 4'(dmem); v.wmem = wmem;
        v.req = req; v.ack = ack; v.br = br;
        return v;
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        src1_decode = v.s1; src2_decode = v.s2; use_src1 = v.u1; use_src2 = v.u2;
        reg_dest_execute = v.dex; wbs_execute = v.wex; mm_execute = v.mmex;
        reg_dest_memory = v.dmem; wbs_memory = v.wmem;
        mem_req = v.req; mem_ack = v.ack; branch_taken = v.br;
    endtask

    // Called at posedge+1; checks mid-cycle, returns at next posedge+1.
    task automatic step(input in_t v, input logic [10:0] exp, input string name);
        drive(v);
        #4;
        check(name, outs(), exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [1:0] fwd_ref(input bit use_src, input logic [3:0] src, input in_t v);
        if (!use_src) return 2'b00;
        if (v.wex && !v.mmex && v.dex == src) return 2'b01;
        if (v.wmem && v.dmem == src) return 2'b10;
        return 2'b00;
    endfunction

    vec_t vecs[12];
    in_t  idle;

    // Reference model state: waiting on memory, flush cycles still owed, held forwards
    bit         m_wait;
    int         m_flush;
    logic [1:0] m_ha, m_hb;
    int         m_sc, m_fc;

    initial begin
        idle = mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset: outputs forced low even with hazards on the inputs
        rst_n = 1'b0;
        drive(mkin(3, 3, 1, 1, 3, 1, 1, 3, 1, 1, 0, 1));
        #7;
        check("reset_outputs", outs(), 11'b000_00_00_00_00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        vecs[0]  = '{mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 11'b000_00_00_00_00};
        vecs[1]  = '{mkin(3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0), 11'b100_01_00_00_00};
        vecs[2]  = '{mkin(1, 7, 0, 1, 7, 1, 1, 0, 0, 0, 0, 0), 11'b100_01_00_00_00};
        vecs[3]  = '{mkin(3, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0), 11'b000_00_00_00_00};
        vecs[4]  = '{mkin(1, 5, 0, 1, 5, 1, 0, 5, 1, 0, 0, 0), 11'b000_00_00_01_00};
        vecs[5]  = '{mkin(6, 0, 1, 0, 2, 1, 0, 6, 1, 0, 0, 0), 11'b000_00_10_00_00};
        vecs[6]  = '{mkin(2, 2, 1, 1, 2, 1, 0, 2, 1, 0, 0, 0), 11'b000_00_01_01_00};
        vecs[7]  = '{mkin(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0), 11'b000_00_01_00_00};
        vecs[8]  = '{mkin(4, 4, 1, 1, 4, 0, 0, 4, 1, 0, 0, 0), 11'b000_00_10_10_00};
        vecs[9]  = '{mkin(3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 1), 11'b000_11_00_00_00};
        vecs[10] = '{mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), 11'b000_11_00_00_00};
        vecs[11] = '{mkin(9, 0, 1, 0, 9, 1, 0, 0, 0, 1, 0, 0), 11'b000_00_01_00_00};

        for (int i = 0; i < 12; i++) begin
            do_reset();
            step(vecs[i].in, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Load-use bubble, then the load forwards from memory
        do_reset();
        step(mkin(3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0), 11'b100_01_00_00_00, "lu_stall");
        step(mkin(3, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0), 11'b000_00_10_00_00, "lu_fwd_mem");

        // Memory wait of 3 cycles with forward selects held
        do_reset();
        step(mkin(5, 0, 1, 0, 5, 1, 0, 0, 0, 1, 0, 0), 11'b000_00_01_00_00, "mw_req");
        step(idle, 11'b111_00_01_00_01, "mw_wait1");
        step(idle, 11'b111_00_01_00_01, "mw_wait2");
        step(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 11'b111_00_01_00_01, "mw_ack");
        step(idle, 11'b000_00_00_00_00, "mw_run");

        // Branch flush for 2 cycles; load-use suppressed while flushing
        do_reset();
        step(mkin(3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 1), 11'b000_11_00_00_00, "br_run");
        step(mkin(3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0), 11'b000_11_00_00_10, "br_flush");
        step(mkin(3, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0), 11'b100_01_00_00_00, "br_back_run");

        // Memory wait with branch held, then flush; reset dropped mid-flush
        do_reset();
        step(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), 11'b000_00_00_00_00, "mwb_req");
        step(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 11'b111_00_00_00_01, "mwb_wait");
        step(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 11'b111_00_00_00_01, "mwb_ack");
        drive(idle);
        #4;
        check("mwb_flush1", outs(), 11'b000_11_00_00_10);
        rst_n = 1'b0;
        #1;
        check("mwb_reset_mid_flush", outs(), 11'b000_00_00_00_00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(idle, 11'b000_00_00_00_00, "mwb_after_reset");

`ifdef PERF_COUNTERS_EN
        // Long stall saturates the stall counter
        do_reset();
        step(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 11'b000_00_00_00_00, "sat_req");
        for (int i = 0; i < 20; i++) begin
            step(idle, 11'b111_00_00_00_01, "sat_wait");
        end
        #4;
        check("sat_stall_cnt", {7'b0, stall_cnt}, {7'b0, 4'hF});
        check("sat_flush_cnt", {7'b0, flush_cnt}, 11'd0);
        @(posedge clk);
        #1;
`endif

        // Random stimulus against the model
        do_reset();
        m_wait = 0; m_flush = 0; m_ha = 2'b00; m_hb = 2'b00; m_sc = 0; m_fc = 0;
        for (int c = 0; c < 800; c++) begin
            in_t        v;
            logic [1:0] la, lb;
            logic [10:0] e;
            bit         lu, brn, sf, ff;
            v = mkin($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                     ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                     ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 79) == 0) begin
                rst_n = 1'b0;
                drive(v);
                #4;
                check("rand_reset", outs(), 11'b000_00_00_00_00);
                m_wait = 0; m_flush = 0; m_ha = 2'b00; m_hb = 2'b00; m_sc = 0; m_fc = 0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                continue;
            end
            drive(v);
            #4;
            la = fwd_ref(v.u1, v.s1, v);
            lb = fwd_ref(v.u2, v.s2, v);
            lu = v.mmex && v.wex && ((v.u1 && v.s1 == v.dex) || (v.u2 && v.s2 == v.dex));
            if (m_wait) begin
                e = {3'b111, 2'b00, m_ha, m_hb, 2'b01};
            end else if (m_flush > 0) begin
                e = {3'b000, 2'b11, la, lb, 2'b10};
            end else begin
                brn = v.br && !(v.req && !v.ack);
                e = {(lu && !brn), 2'b00, brn, (brn || lu), la, lb, 2'b00};
            end
            check($sformatf("rand%0d", c), outs(), e);
`ifdef PERF_COUNTERS_EN
            check($sformatf("rand_scnt%0d", c), {7'b0, stall_cnt}, 11'(m_sc));
            check($sformatf("rand_fcnt%0d", c), {7'b0, flush_cnt}, 11'(m_fc));
`endif
            sf = e[10];
            ff = e[7];
            if (sf && m_sc < (1 << PW) - 1) m_sc++;
            if (ff && m_fc < (1 << PW) - 1) m_fc++;
            @(posedge clk);
            if (m_wait) begin
                if (v.ack) begin
                    m_wait  = 0;
                    m_flush = v.br ? FC : 0;
                end
            end else if (m_flush > 0) begin
                m_flush--;
            end else if (v.req && !v.ack) begin
                m_wait = 1;
                m_ha   = la;
                m_hb   = lb;
            end else if (v.br) begin
                m_flush = FC - 1;
            end
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
